// File: rtl/div_issue_pkg.sv
// Shared defines for the M-extension divide path: operand widths, funct3 op
// encodings, issue-FSM state encoding and the default divider watchdog limit.
package div_issue_pkg;

  localparam int DIV_W       = 32;
  localparam int REG_AW      = 5;
  localparam int DIV_TIMEOUT = 64;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    WB   = 2'b10
  } div_state_e;

  typedef struct packed {
    logic [2:0]        op;
    logic [DIV_W-1:0]  dividend;
    logic [DIV_W-1:0]  divisor;
    logic [REG_AW-1:0] rd;
  } div_req_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/div_wdog.sv
// Watchdog counter for the divide wait phase; tc flags the last permitted cycle.
module div_wdog
  import div_issue_pkg::*;
#(
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // saturate at the terminal value so an idle-held enable can never wrap
  always_ff @(posedge clk) begin
    if (rst)              r_cnt <= '0;
    else if (clr)         r_cnt <= '0;
    else if (en && !tc)   r_cnt <= r_cnt + 1'b1;
  end

  assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/div_issue.sv
// Issue/write-back sequencer between the execute stage and the iterative
// divider: latches operands, stalls the pipe, writes back one result.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [2:0]        op_i,
  input  logic [DIV_W-1:0]  rs1_data_i,
  input  logic [DIV_W-1:0]  rs2_data_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flush_i,
  output logic              div_start_o,
  output logic [2:0]        div_op_o,
  output logic [DIV_W-1:0]  div_dividend_o,
  output logic [DIV_W-1:0]  div_divisor_o,
  output logic [REG_AW-1:0] div_reg_waddr_o,
  input  logic [DIV_W-1:0]  div_result_i,
  input  logic              div_ready_i,
  input  logic              div_busy_i,
  output logic              hold_o,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [DIV_W-1:0]  reg_wdata_o,
  output logic              err_o
);

  div_state_e        r_state, w_next;
  div_req_t          r_req;
  logic [REG_AW-1:0] r_waddr;
  logic [DIV_W-1:0]  r_wdata;
  logic              r_err;

  logic w_accept, w_in_wait, w_tc, w_wb_load, w_err;

  // busy gating guarantees the divider sees start low between operations
  assign w_accept  = (r_state == IDLE) && req_i && is_div_op(op_i) &&
                     !flush_i && !div_busy_i && !rst;
  assign w_in_wait = (r_state == WAIT);

  div_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .en  (w_in_wait),
    .tc  (w_tc)
  );

  always_comb begin
    w_next    = r_state;
    w_wb_load = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = WAIT;
      WAIT: begin
        if (flush_i) begin
          w_next = IDLE;
        end else if (div_ready_i) begin
          w_next    = WB;
          w_wb_load = 1'b1;
        end else if (w_tc) begin
          w_next = IDLE;
          w_err  = 1'b1;
        end
      end
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      if (w_accept)
        r_req <= '{op: op_i, dividend: rs1_data_i, divisor: rs2_data_i, rd: rd_i};
      if (w_wb_load) begin
        r_wdata <= div_result_i;
        r_waddr <= r_req.rd;
      end
    end
  end

  // start drops in the ready cycle so the divider does not relaunch
  assign div_start_o     = w_in_wait && !div_ready_i && !flush_i;
  assign div_op_o        = r_req.op;
  assign div_dividend_o  = r_req.dividend;
  assign div_divisor_o   = r_req.divisor;
  assign div_reg_waddr_o = r_req.rd;

  assign hold_o      = w_accept || w_in_wait;
  assign reg_we_o    = (r_state == WB) && (r_waddr != '0);
  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: divider stub with programmable latency plus a
// RISC-V divide reference model; directed scenarios then random operations.
module tb_div_issue;
  import div_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        div_start_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_dividend_o, div_divisor_o;
  logic [4:0]  div_reg_waddr_o;
  logic [31:0] div_result_i;
  logic        div_ready_i, div_busy_i;
  logic        hold_o, reg_we_o, err_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  logic        s_busy = 1'b0;
  logic        s_rdy = 1'b0;
  logic [31:0] s_res = '0;
  int          s_cnt = 0;
  int          stub_lat = 2;
  bit          stub_mute = 1'b0;
  bit          busy_force = 1'b0;

  int passed = 0, fails = 0, total = 0;
  int wr_cnt = 0, err_cnt = 0;

  assign div_ready_i  = s_rdy;
  assign div_busy_i   = s_busy | busy_force;
  assign div_result_i = s_res;

  div_issue #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .flush_i(flush_i), .div_start_o(div_start_o), .div_op_o(div_op_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_reg_waddr_o(div_reg_waddr_o), .div_result_i(div_result_i),
    .div_ready_i(div_ready_i), .div_busy_i(div_busy_i), .hold_o(hold_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension semantics including divide-by-zero and overflow
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return sa / sb;
      OP_DIVU: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      OP_REM:  if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
               else return sa % sb;
      OP_REMU: if (b == 0) return a; else return a % b;
      default: return 32'h0;
    endcase
  endfunction

  // divider stub: latches on start, answers after stub_lat cycles, aborts when start drops
  always @(posedge clk) begin
    if (rst) begin
      s_busy <= 1'b0;
      s_rdy  <= 1'b0;
      s_cnt  <= 0;
    end else if (s_rdy) begin
      s_rdy  <= 1'b0;
      s_busy <= 1'b0;
    end else if (!s_busy) begin
      if (div_start_o) begin
        s_busy <= 1'b1;
        s_cnt  <= stub_lat;
      end
    end else if (!div_start_o) begin
      s_busy <= 1'b0;
    end else if (s_cnt == 0) begin
      if (!stub_mute) begin
        s_rdy <= 1'b1;
        s_res <= ref_div(div_op_o, div_dividend_o, div_divisor_o);
      end
    end else begin
      s_cnt <= s_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (reg_we_o) wr_cnt <= wr_cnt + 1;
    if (err_o)    err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input bit flush_wb);
    logic [31:0] exp;
    int w0, n;
    exp = ref_div(op, a, b);
    stub_lat = lat;
    stub_mute = 1'b0;
    @(negedge clk);
    req_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
    #1;
    chk("hold_accept", hold_o, 1);
    w0 = wr_cnt;
    @(negedge clk);
    req_i = 1'b0; op_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom; rd_i = 5'($urandom);
    #1;
    chk("start_in_wait", div_start_o, 1);
    chk("div_op", div_op_o, op);
    chk("div_dividend", div_dividend_o, a);
    chk("div_divisor", div_divisor_o, b);
    chk("div_rd", div_reg_waddr_o, rd);
    n = 0;
    while (!div_ready_i && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", (n < 100), 1);
    chk("start_low_on_ready", div_start_o, 0);
    chk("hold_on_ready", hold_o, 1);
    @(negedge clk);
    if (flush_wb) begin
      flush_i = 1'b1;
      #1;
    end
    chk("wb_we", reg_we_o, (rd != 0));
    chk("wb_waddr", reg_waddr_o, rd);
    chk("wb_wdata", reg_wdata_o, exp);
    chk("wb_hold", hold_o, 0);
    chk("wb_start", div_start_o, 0);
    flush_i = 1'b0;
    @(negedge clk);
    chk("post_we", reg_we_o, 0);
    chk("post_start", div_start_o, 0);
    chk("write_count", wr_cnt - w0, (rd != 0));
  endtask

  initial begin
    int w0, e0, k;
    logic [31:0] a, b;
    int sel;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", div_start_o, 0);
    chk("rst_hold", hold_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_dividend", div_dividend_o, 0);
    rst = 1'b0;

    // signed divide, divide by zero, write to x0
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 4, 1'b0);
    run_op(OP_REMU, 32'h0000_1234, 32'd0, 5'd8, 3, 1'b0);
    run_op(OP_DIVU, 32'd100,       32'd7, 5'd0, 2, 1'b0);

    // non-divide funct3 is ignored
    @(negedge clk);
    req_i = 1'b1; op_i = 3'b000; rs1_data_i = 32'd6; rs2_data_i = 32'd7; rd_i = 5'd3;
    #1;
    chk("mul_hold", hold_o, 0);
    @(negedge clk);
    req_i = 1'b0;
    #1;
    chk("mul_start", div_start_o, 0);
    chk("mul_hold2", hold_o, 0);

    // divider busy blocks acceptance
    busy_force = 1'b1;
    @(negedge clk);
    req_i = 1'b1; op_i = OP_DIV; rs1_data_i = 32'd10; rs2_data_i = 32'd2; rd_i = 5'd1;
    #1;
    chk("busy_hold", hold_o, 0);
    @(negedge clk);
    #1;
    chk("busy_start", div_start_o, 0);
    req_i = 1'b0;
    busy_force = 1'b0;

    // flush mid-divide, then a clean DIV 9/3
    stub_lat = 30;
    @(negedge clk);
    req_i = 1'b1; op_i = OP_DIV; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_i = 5'd3;
    @(negedge clk);
    req_i = 1'b0;
    w0 = wr_cnt;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_start", div_start_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_idle_hold", hold_o, 0);
    chk("flush_idle_start", div_start_o, 0);
    repeat (3) @(negedge clk);
    chk("flush_no_write", wr_cnt - w0, 0);
    run_op(OP_DIV, 32'd9, 32'd3, 5'd7, 2, 1'b0);

    // flush during write-back does not cancel the retired write
    run_op(OP_DIVU, 32'd1000, 32'd10, 5'd12, 1, 1'b1);

    // divider never answers: watchdog; requests during WAIT must be ignored
    stub_mute = 1'b1;
    stub_lat = 0;
    @(negedge clk);
    req_i = 1'b1; op_i = OP_DIVU; rs1_data_i = 32'd50; rs2_data_i = 32'd5; rd_i = 5'd4;
    w0 = wr_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rs1_data_i = 32'hDEAD_BEEF;
    k = 0;
    while (!err_o && k < 200) begin
      if (hold_o) k++;
      if (k == 10) req_i = 1'b0;
      @(negedge clk);
    end
    req_i = 1'b0;
    chk("tmo_wait_cycles", 32'(k), 64);
    chk("tmo_dividend_held", div_dividend_o, 32'd50);
    chk("tmo_hold", hold_o, 0);
    chk("tmo_start", div_start_o, 0);
    chk("tmo_we", reg_we_o, 0);
    @(negedge clk);
    chk("tmo_err_pulse", err_o, 0);
    chk("tmo_err_count", err_cnt - e0, 1);
    chk("tmo_no_write", wr_cnt - w0, 0);
    stub_mute = 1'b0;

    // reset mid-divide
    stub_lat = 20;
    @(negedge clk);
    req_i = 1'b1; op_i = OP_REM; rs1_data_i = 32'd100; rs2_data_i = 32'd3; rd_i = 5'd9;
    @(negedge clk);
    req_i = 1'b0;
    repeat (3) @(negedge clk);
    w0 = wr_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_start", div_start_o, 0);
    chk("mrst_hold", hold_o, 0);
    chk("mrst_we", reg_we_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_op", div_op_o, 0);
    chk("mrst_dividend", div_dividend_o, 0);
    chk("mrst_divisor", div_divisor_o, 0);
    chk("mrst_rd", div_reg_waddr_o, 0);
    chk("mrst_waddr", reg_waddr_o, 0);
    chk("mrst_wdata", reg_wdata_o, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("mrst_no_write", wr_cnt - w0, 0);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 3, 1'b0);

    // random operations including corner operands
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(7, 0);
      a = $urandom;
      b = $urandom;
      if (sel == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 1) b = 32'd0;
      else if (sel == 2) b = 32'($urandom_range(9, 1));
      run_op({1'b1, 2'($urandom)}, a, b, 5'($urandom), $urandom_range(5, 0), ($urandom_range(3, 0) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  execute stage presents an M-extension divide instruction
- op_i  in  3  funct3: DIV=100, DIVU=101, REM=110, REMU=111
- rs1_data_i  in  32  dividend
- rs2_data_i  in  32  divisor
- rd_i  in  5  destination register
- flush_i  in  1  pipeline flush (jump or interrupt); aborts any divide in flight
- div_start_o  out  1  start to divider; held high for the whole operation
- div_op_o  out  3  latched op
- div_dividend_o  out  32  latched dividend
- div_divisor_o  out  32  latched divisor
- div_reg_waddr_o  out  5  latched rd
- div_result_i  in  32  divider result (sign already applied)
- div_ready_i  in  1  divider result valid; one-cycle pulse
- div_busy_i  in  1  divider running
- hold_o  out  1  stall request to the pipeline
- reg_we_o  out  1  register-file write enable
- reg_waddr_o  out  5  register-file write address
- reg_wdata_o  out  32  register-file write data
- err_o  out  1  one-cycle pulse on divider timeout
REQ-003 Parameter TIMEOUT, default 64: maximum number of WAIT cycles before the block aborts.

Function
REQ-004 FSM states SHALL be IDLE, WAIT and WB.
REQ-005 IDLE to WAIT SHALL occur when req_i=1, op_i[2]=1, flush_i=0 and div_busy_i=0; on that edge the block SHALL latch op, rs1, rs2 and rd into the div_* outputs.
REQ-006 A request with op_i[2]=0 SHALL be ignored, and hold_o SHALL stay low for it.
REQ-007 div_start_o SHALL equal (state==WAIT) AND NOT div_ready_i AND NOT flush_i, combinationally, so the divider sees start low in the cycle its ready pulse is high and does not restart.
REQ-008 WAIT to WB SHALL occur when div_ready_i=1 and flush_i=0; on that edge the block SHALL register div_result_i into reg_wdata_o and the latched rd into reg_waddr_o.
REQ-009 In WB, reg_we_o SHALL be 1 for exactly one cycle, unless rd=0, in which case reg_we_o SHALL be 0; WB SHALL always go to IDLE next cycle.
REQ-010 Write-back SHALL occur exactly one cycle after div_ready_i is sampled high.
REQ-011 hold_o SHALL be 1 in the accepting IDLE cycle and in every WAIT cycle, and SHALL be 0 in WB and otherwise.
REQ-012 flush_i=1 in WAIT SHALL drop div_start_o in the same cycle and return the FSM to IDLE with no write; flush_i has priority over a simultaneous div_ready_i.
REQ-013 flush_i=1 in WB SHALL NOT suppress the pending write, because the instruction has already retired.
REQ-014 A timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-015 When the timeout counter reaches TIMEOUT-1 with div_ready_i=0, the block SHALL return to IDLE, drop div_start_o, pulse err_o for one cycle and perform no write.
REQ-016 No request SHALL be accepted in WAIT or WB.
REQ-017 No request SHALL be accepted while div_busy_i=1; this guarantees at least one start-low cycle between consecutive operations.
REQ-018 The div_* data outputs SHALL hold their latched values until the next accept.

Reset
REQ-019 With rst=1 at a clock edge, the state SHALL go to IDLE, and the timeout counter, all latched fields, reg_w* and err_o SHALL clear to 0.
REQ-020 During reset, div_start_o, hold_o and reg_we_o SHALL be 0 in the following cycle.
REQ-021 Reset mid-operation SHALL discard the operation with no write; the divider aborts because start is low.

Structure
REQ-022 The op encodings, the TIMEOUT default and the FSM state encoding SHALL live in the shared defines package next to the existing divider encodings.
REQ-023 The timeout counter SHALL be a small counter sub-module named div_wdog with inputs clr, en and a terminal-count output.
REQ-024 No other sub-module SHALL be used.

Verification
REQ-025 Bench scenario (normal signed divide, paired with the existing divider): DIV rs1=-7 (0xFFFFFFF9), rs2=2, rd=5 -> one write with reg_waddr_o=5 and reg_wdata_o=0xFFFFFFFD; hold_o falls in the WB cycle; div_start_o is never reasserted after ready.
REQ-026 Bench scenario (divide by zero): REMU rs1=0x1234, rs2=0 -> reg_wdata_o=0x1234, written exactly one cycle after the ready pulse.
REQ-027 Bench scenario (write to x0): DIVU 100/7 with rd=0 -> full handshake completes, reg_we_o stays 0, hold_o is released.
REQ-028 Bench scenario (flush mid-divide): assert flush_i 10 cycles into WAIT -> div_start_o is low in that same cycle, the FSM returns to IDLE, there is no write; the next DIV 9/3 issued afterwards writes 3.
REQ-029 Bench scenario (divider stub never answers): -> err_o pulses after 64 WAIT cycles, there is no write, hold_o drops.
REQ-030 Bench scenario (reset mid-divide): assert rst during WAIT -> all outputs are 0 the next cycle; a later REM -7/2 writes 0xFFFFFFFF.
